// File: rtl/fake_n64_pkg.sv
// Shared types and constants for the fake N64 controller: sequencer states,
// command bytes and the response length for each command.
package fake_n64_pkg;

  typedef enum logic [2:0] {
    StRx,
    StDecode,
    StTurn,
    StTx,
    StGuard
  } seq_state_e;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hff;

  // Response lengths in bytes (READ carries 32 data bytes plus a CRC byte)
  localparam logic [5:0] LEN_INFO   = 6'd3;
  localparam logic [5:0] LEN_STATUS = 6'd4;
  localparam logic [5:0] LEN_READ   = 6'd33;
  localparam logic [5:0] LEN_WRITE  = 6'd1;
  localparam logic [5:0] LEN_RESET  = 6'd3;

  localparam logic [7:0] TX_CMD_IDLE = 8'hfe;

  // Response length for a command; 0 marks an unknown command
  function automatic logic [5:0] cmd_len(input logic [7:0] c);
    logic [5:0] len;
    case (c)
      CMD_INFO:   len = LEN_INFO;
      CMD_STATUS: len = LEN_STATUS;
      CMD_READ:   len = LEN_READ;
      CMD_WRITE:  len = LEN_WRITE;
      CMD_RESET:  len = LEN_RESET;
      default:    len = 6'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchroniser plus change detector: turns each level change of a
// toggle from another clock domain into a one-cycle event. Flops reset to 0,
// matching the reset level of the toggle source.
module toggle_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  output logic evt_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Next-state of the synchroniser chain and detector history
  always_comb begin
    sync1_d = tgl_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and detector registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign evt_o = sync2_q ^ prev_q;

endmodule

// File: rtl/fake_n64_line_sequencer.sv
// Half-duplex line sequencer: decodes each received command, turns the line
// around, starts the transmitter, guards after transmit and returns to receive.
// Optional receive watchdog is built when FAKE_N64_SEQ_WATCHDOG_EN is defined.
module fake_n64_line_sequencer
  import fake_n64_pkg::*;
#(
  parameter int unsigned TURNAROUND_CYCLES = 32,
  parameter int unsigned GUARD_CYCLES      = 64,
  parameter int unsigned RX_TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_handoff,
  input  logic       rx_bit_strobe,
  input  logic [7:0] cmd,
  input  logic       tx_done,
  output logic       cur_operation,
  output logic       tx_start,
  output logic [7:0] tx_cmd,
  output logic [5:0] tx_byte_count,
  output logic       rx_reset,
  output logic       overrun,
  output logic       bad_cmd
);

  localparam logic [15:0] TURN_LOAD  = 16'(TURNAROUND_CYCLES - 1);
  localparam logic [15:0] GUARD_LOAD = 16'(GUARD_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        cur_op_q, cur_op_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_cmd_q, tx_cmd_d;
  logic [5:0]  tx_len_q, tx_len_d;
  logic        rx_reset_q, rx_reset_d;
  logic        overrun_q, overrun_d;
  logic        bad_cmd_q, bad_cmd_d;
  logic        hs_evt;
  logic        wd_fire;

  toggle_sync u_hs_sync (
    .clk_i (clk),
    .rst_i (reset),
    .tgl_i (rx_handoff),
    .evt_o (hs_evt)
  );

`ifdef FAKE_N64_SEQ_WATCHDOG_EN
  localparam logic [15:0] TO_LAST = 16'(RX_TIMEOUT_CYCLES - 1);

  logic [15:0] idle_q, idle_d;
  logic        armed_q, armed_d;

  // Idle watchdog: armed by a strobe in RX, fires after the idle limit, then
  // waits for the next strobe. A handoff in the same cycle takes priority.
  always_comb begin
    idle_d  = idle_q;
    armed_d = armed_q;
    wd_fire = 1'b0;
    if (state_q == StRx && !hs_evt) begin
      if (rx_bit_strobe) begin
        armed_d = 1'b1;
        idle_d  = '0;
      end else if (armed_q) begin
        if (idle_q == TO_LAST) begin
          wd_fire = 1'b1;
          armed_d = 1'b0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
    end else begin
      armed_d = 1'b0;
      idle_d  = '0;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      armed_q <= armed_d;
    end
  end
`else
  logic unused_strobe;
  assign unused_strobe = rx_bit_strobe;
  assign wd_fire       = 1'b0;
`endif

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    tx_start_d = 1'b0;
    tx_cmd_d   = tx_cmd_q;
    tx_len_d   = tx_len_q;
    rx_reset_d = wd_fire;
    overrun_d  = overrun_q;
    bad_cmd_d  = bad_cmd_q;

    unique case (state_q)
      StRx: begin
        if (hs_evt) state_d = StDecode;
      end
      StDecode: begin
        if (hs_evt) overrun_d = 1'b1;
        tx_cmd_d = cmd;
        tx_len_d = cmd_len(cmd);
        if (cmd_len(cmd) != 6'd0) begin
          state_d = StTurn;
          cnt_d   = TURN_LOAD;
        end else begin
          bad_cmd_d  = 1'b1;
          rx_reset_d = 1'b1;
          state_d    = StRx;
        end
      end
      StTurn: begin
        if (hs_evt) overrun_d = 1'b1;
        if (cnt_q == '0) begin
          state_d    = StTx;
          tx_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StTx: begin
        if (hs_evt) overrun_d = 1'b1;
        if (tx_done) begin
          state_d = StGuard;
          cnt_d   = GUARD_LOAD;
        end
      end
      StGuard: begin
        // One handoff may wait out the guard; a second one is lost
        if (hs_evt) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d   = (pending_q || hs_evt) ? StDecode : StRx;
          pending_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StRx;
    endcase

    cur_op_d = (state_d == StTurn) || (state_d == StTx);
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRx;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      cur_op_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_cmd_q   <= TX_CMD_IDLE;
      tx_len_q   <= '0;
      rx_reset_q <= 1'b0;
      overrun_q  <= 1'b0;
      bad_cmd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      cur_op_q   <= cur_op_d;
      tx_start_q <= tx_start_d;
      tx_cmd_q   <= tx_cmd_d;
      tx_len_q   <= tx_len_d;
      rx_reset_q <= rx_reset_d;
      overrun_q  <= overrun_d;
      bad_cmd_q  <= bad_cmd_d;
    end
  end

  assign cur_operation = cur_op_q;
  assign tx_start      = tx_start_q;
  assign tx_cmd        = tx_cmd_q;
  assign tx_byte_count = tx_len_q;
  assign rx_reset      = rx_reset_q;
  assign overrun       = overrun_q;
  assign bad_cmd       = bad_cmd_q;

endmodule
